// File: rtl/jtag_dm_access_pkg.sv
// Shared DMI codes, default widths and FSM encoding for the DMI access engine.
package jtag_dm_access_pkg;

  localparam int unsigned DEF_ADDR_BITS      = 7;
  localparam int unsigned DEF_DATA_BITS      = 32;
  localparam int unsigned DEF_OP_BITS        = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  // DMI request op codes; 2'b11 is reserved and answered with FAILED.
  localparam logic [1:0] DMI_OP_NOP   = 2'b00;
  localparam logic [1:0] DMI_OP_READ  = 2'b01;
  localparam logic [1:0] DMI_OP_WRITE = 2'b10;

  // DMI response status codes; BUSY (2'b11) is never produced by this engine.
  localparam logic [1:0] DMI_STATUS_OK     = 2'b00;
  localparam logic [1:0] DMI_STATUS_FAILED = 2'b10;

  // One-hot FSM encoding.
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_WAIT = 4'b0100,
    ST_RESP = 4'b1000
  } dm_state_e;

  // Timeout counter width; a disabled timeout still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/jtag_dm_access_if.sv
// DMI request/response handshake plus debug-module register bus.
interface jtag_dm_access_if
  import jtag_dm_access_pkg::*;
#(
  parameter int unsigned A = DEF_ADDR_BITS,
  parameter int unsigned D = DEF_DATA_BITS,
  parameter int unsigned O = DEF_OP_BITS
) ();

  logic             req_valid_i;
  logic [A+D+O-1:0] req_data_i;
  logic             req_ready_o;
  logic             resp_valid_o;
  logic [A+D+O-1:0] resp_data_o;
  logic             resp_ready_i;
  logic             dm_req_o;
  logic             dm_we_o;
  logic [A-1:0]     dm_addr_o;
  logic [D-1:0]     dm_wdata_o;
  logic             dm_gnt_i;
  logic             dm_rvalid_i;
  logic [D-1:0]     dm_rdata_i;
  logic             dm_err_i;

  // Access engine side.
  modport slave (
    input  req_valid_i, req_data_i, resp_ready_i,
    input  dm_gnt_i, dm_rvalid_i, dm_rdata_i, dm_err_i,
    output req_ready_o, resp_valid_o, resp_data_o,
    output dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o
  );

  // CDC / register-bus side.
  modport master (
    output req_valid_i, req_data_i, resp_ready_i,
    output dm_gnt_i, dm_rvalid_i, dm_rdata_i, dm_err_i,
    input  req_ready_o, resp_valid_o, resp_data_o,
    input  dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o
  );

endinterface

// File: rtl/jtag_dm_access.sv
// Core-domain DMI access engine: one DMI request at a time is turned into a
// debug-module register bus access and answered with {addr, data, status}.
module jtag_dm_access
  import jtag_dm_access_pkg::*;
#(
  parameter int unsigned DMI_ADDR_BITS  = DEF_ADDR_BITS,
  parameter int unsigned DMI_DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned DMI_OP_BITS    = DEF_OP_BITS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic             clk,
  input logic             rst_n,
  jtag_dm_access_if.slave dmi
);

  localparam int unsigned A     = DMI_ADDR_BITS;
  localparam int unsigned D     = DMI_DATA_BITS;
  localparam int unsigned O     = DMI_OP_BITS;
  localparam int unsigned W     = A + D + O;
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  dm_state_e        r_state;
  dm_state_e        w_state_next;
  logic [A-1:0]     r_addr;
  logic [D-1:0]     r_wdata;
  logic             r_we;
  logic [W-1:0]     r_resp;
  logic [CNT_W-1:0] r_cnt;

  logic [A-1:0]     w_req_addr;
  logic [D-1:0]     w_req_data;
  logic [O-1:0]     w_req_op;
  logic             w_req_rw;
  logic             w_at_limit;
  logic             w_accept;
  logic             w_busy;
  logic             w_done;
  logic             w_timeout;

  // Request field split and op decode.
  assign w_req_addr = dmi.req_data_i[W-1:D+O];
  assign w_req_data = dmi.req_data_i[D+O-1:O];
  assign w_req_op   = dmi.req_data_i[O-1:0];
  assign w_req_rw   = (w_req_op == O'(DMI_OP_READ)) || (w_req_op == O'(DMI_OP_WRITE));
  assign w_at_limit = TO_EN && (r_cnt >= CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state; completion wins over timeout in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dmi.req_valid_i) begin
          w_accept     = 1'b1;
          w_state_next = w_req_rw ? ST_REQ : ST_RESP;
        end
      end
      ST_REQ: begin
        w_busy    = 1'b1;
        w_done    = dmi.dm_gnt_i && dmi.dm_rvalid_i;
        w_timeout = !w_done && w_at_limit;
        if (w_done || w_timeout) begin
          w_state_next = ST_RESP;
        end else if (dmi.dm_gnt_i) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_busy    = 1'b1;
        w_done    = dmi.dm_rvalid_i;
        w_timeout = !w_done && w_at_limit;
        if (w_done || w_timeout) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (dmi.resp_ready_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from one-hot state flops and the captured request.
  always_comb begin
    dmi.req_ready_o  = (r_state == ST_IDLE);
    dmi.dm_req_o     = (r_state == ST_REQ);
    dmi.resp_valid_o = (r_state == ST_RESP);
    dmi.resp_data_o  = r_resp;
    dmi.dm_we_o      = r_we;
    dmi.dm_addr_o    = r_addr;
    dmi.dm_wdata_o   = r_wdata;
  end

  // Request capture, timeout counter and response assembly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_resp  <= '0;
    end else if (w_accept) begin
      r_addr  <= w_req_addr;
      r_wdata <= w_req_data;
      r_we    <= (w_req_op == O'(DMI_OP_WRITE));
      r_cnt   <= '0;
      // Only NOP/reserved go straight to RESP; bus ops overwrite this later.
      r_resp  <= {w_req_addr, D'(0),
                  (w_req_op == O'(DMI_OP_NOP)) ? O'(DMI_STATUS_OK) : O'(DMI_STATUS_FAILED)};
    end else if (w_busy) begin
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_done) begin
        r_resp <= {r_addr, r_we ? r_wdata : dmi.dm_rdata_i,
                   dmi.dm_err_i ? O'(DMI_STATUS_FAILED) : O'(DMI_STATUS_OK)};
      end else if (w_timeout) begin
        r_resp <= {r_addr, D'(0), O'(DMI_STATUS_FAILED)};
      end
    end
  end

endmodule

// File: tb/tb_jtag_dm_access.sv
// Transaction-scheduled bench: each DMI transaction is planned as a per-cycle
// table of inputs and expected outputs computed from the protocol timing rules.
module tb_jtag_dm_access;
  import jtag_dm_access_pkg::*;

  localparam int TO = 4;
  localparam int NC = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtag_dm_access_if #(.A(7), .D(32), .O(2)) dif ();

  jtag_dm_access #(
    .DMI_ADDR_BITS (7),
    .DMI_DATA_BITS (32),
    .DMI_OP_BITS   (2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dmi  (dif)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle stimulus and expectation tables for the current plan.
  bit          s_rst[NC], s_valid[NC], s_gnt[NC], s_rvalid[NC], s_err[NC], s_rready[NC];
  logic [1:0]  s_op[NC];
  logic [6:0]  s_addr[NC];
  logic [31:0] s_wdata[NC], s_rdata[NC];
  bit          e_ready[NC], e_rvalid[NC], e_dmreq[NC], e_zero[NC], e_we[NC];
  logic [40:0] e_resp[NC];
  logic [6:0]  e_addr[NC];
  logic [31:0] e_wdata[NC];
  int          plan_len;

  // Observations of the last executed plan, pinned by literal checks.
  int          n_req_hi;
  int          first_rel;
  logic [40:0] first_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [40:0] mk(input logic [6:0] a, input logic [31:0] d, input logic [1:0] s);
    return {a, d, s};
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < NC; i++) begin
      s_rst[i] = 0; s_valid[i] = 0; s_gnt[i] = 0; s_rvalid[i] = 0; s_err[i] = 0; s_rready[i] = 0;
      s_op[i] = 2'($urandom); s_addr[i] = 7'($urandom);
      s_wdata[i] = $urandom; s_rdata[i] = $urandom;
      e_ready[i] = 1; e_rvalid[i] = 0; e_dmreq[i] = 0; e_zero[i] = 0; e_we[i] = 0;
      e_resp[i] = '0; e_addr[i] = '0; e_wdata[i] = '0;
    end
  endtask

  // Plan one transaction accepted at cycle 0. Bus grant comes g cycles after
  // dm_req rises, rvalid r cycles after grant; the response is held h cycles.
  task automatic plan_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                          input int g, input int r, input logic [31:0] rdata, input bit err,
                          input int h, input int gap, input bit spur, input bit press);
    int last, req_end, rs, len;
    bit rw, done;
    logic [40:0] resp;
    clear_plan();
    s_valid[0] = 1; s_op[0] = op; s_addr[0] = addr; s_wdata[0] = data;
    rw = (op == DMI_OP_READ) || (op == DMI_OP_WRITE);
    last = 0;
    len = 0;
    if (rw) begin
      done    = (g + r + 1 <= TO);
      last    = done ? g + r + 1 : TO;
      req_end = (g + 1 < TO) ? g + 1 : TO;
      for (int c = 1; c <= last; c++) begin
        e_ready[c] = 0;
        e_dmreq[c] = (c <= req_end);
        e_addr[c]  = addr;
        e_we[c]    = (op == DMI_OP_WRITE);
        e_wdata[c] = data;
      end
      s_gnt[g+1] = 1;
      s_rvalid[g+1+r] = 1; s_rdata[g+1+r] = rdata; s_err[g+1+r] = err;
      if (done)
        resp = mk(addr, (op == DMI_OP_WRITE) ? data : rdata, err ? DMI_STATUS_FAILED : DMI_STATUS_OK);
      else
        resp = mk(addr, 32'h0, DMI_STATUS_FAILED);
      len = g + r + 2;
    end else begin
      resp = mk(addr, 32'h0, (op == DMI_OP_NOP) ? DMI_STATUS_OK : DMI_STATUS_FAILED);
    end
    rs = last + 1;
    for (int c = rs; c <= rs + h; c++) begin
      e_ready[c] = 0; e_rvalid[c] = 1; e_resp[c] = resp;
      if (press) s_valid[c] = 1;
    end
    s_rready[rs+h] = 1;
    if (spur) begin
      s_rvalid[rs] = 1; s_err[rs] = 1'($urandom);
    end
    if (rs + h + 1 > len) len = rs + h + 1;
    plan_len = len + gap;
  endtask

  // Play the current plan: at each negedge compare this cycle's outputs, then drive its inputs.
  task automatic exec();
    n_req_hi = 0;
    first_rel = -1;
    first_data = '0;
    for (int c = 0; c < plan_len; c++) begin
      @(negedge clk);
      check("req_ready", 64'(dif.req_ready_o), 64'(e_ready[c]));
      check("resp_valid", 64'(dif.resp_valid_o), 64'(e_rvalid[c]));
      check("dm_req", 64'(dif.dm_req_o), 64'(e_dmreq[c]));
      if (e_rvalid[c]) check("resp_data", 64'(dif.resp_data_o), 64'(e_resp[c]));
      if (e_dmreq[c]) begin
        check("dm_addr", 64'(dif.dm_addr_o), 64'(e_addr[c]));
        check("dm_we", 64'(dif.dm_we_o), 64'(e_we[c]));
        check("dm_wdata", 64'(dif.dm_wdata_o), 64'(e_wdata[c]));
      end
      if (e_zero[c]) begin
        check("rst_resp_data", 64'(dif.resp_data_o), 64'h0);
        check("rst_dm_addr", 64'(dif.dm_addr_o), 64'h0);
        check("rst_dm_we", 64'(dif.dm_we_o), 64'h0);
        check("rst_dm_wdata", 64'(dif.dm_wdata_o), 64'h0);
      end
      if (dif.dm_req_o === 1'b1) n_req_hi++;
      if (dif.resp_valid_o === 1'b1 && first_rel < 0) begin
        first_rel = c;
        first_data = dif.resp_data_o;
      end
      rst_n            = !s_rst[c];
      dif.req_valid_i  = s_valid[c];
      dif.req_data_i   = {s_addr[c], s_wdata[c], s_op[c]};
      dif.resp_ready_i = s_rready[c];
      dif.dm_gnt_i     = s_gnt[c];
      dif.dm_rvalid_i  = s_rvalid[c];
      dif.dm_rdata_i   = s_rdata[c];
      dif.dm_err_i     = s_err[c];
    end
  endtask

  initial begin
    dif.req_valid_i = 0; dif.req_data_i = '0; dif.resp_ready_i = 0;
    dif.dm_gnt_i = 0; dif.dm_rvalid_i = 0; dif.dm_rdata_i = '0; dif.dm_err_i = 0;

    // Reset state.
    clear_plan();
    s_rst[0] = 1; s_rst[1] = 1;
    for (int c = 0; c < 4; c++) e_zero[c] = 1;
    plan_len = 4;
    exec();

    // Read 0x11, grant at bus cycle 1, rvalid one cycle later.
    plan_txn(DMI_OP_READ, 7'h11, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    exec();
    check("lit_read_latency", 64'(first_rel), 64'd3);
    check("lit_read_resp", 64'(first_data), 64'({7'h11, 32'hDEADBEEF, 2'b00}));
    check("lit_read_req_cycles", 64'(n_req_hi), 64'd1);

    // Write with bus error.
    plan_txn(DMI_OP_WRITE, 7'h10, 32'h1, 0, 1, 32'h0, 1, 1, 1, 0, 0);
    exec();
    check("lit_write_err_resp", 64'(first_data), 64'({7'h10, 32'h1, 2'b10}));

    // NOP then reserved op: no bus activity.
    plan_txn(DMI_OP_NOP, 7'h05, 32'hAAAA5555, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    exec();
    check("lit_nop_latency", 64'(first_rel), 64'd1);
    check("lit_nop_resp", 64'(first_data), 64'({7'h05, 32'h0, 2'b00}));
    plan_txn(2'b11, 7'h06, 32'h12345678, 0, 0, 32'h0, 0, 2, 1, 0, 0);
    exec();
    check("lit_rsvd_resp", 64'(first_data), 64'({7'h06, 32'h0, 2'b10}));
    check("lit_rsvd_no_bus", 64'(n_req_hi), 64'd0);

    // Grant never comes: timeout, then a spurious rvalid while idle.
    plan_txn(DMI_OP_READ, 7'h33, 32'h0, 9, 0, 32'hCAFEF00D, 0, 1, 0, 1, 0);
    s_gnt[10] = 0;
    exec();
    check("lit_timeout_req_cycles", 64'(n_req_hi), 64'd4);
    check("lit_timeout_resp", 64'(first_data), 64'({7'h33, 32'h0, 2'b10}));

    // Response back-pressure for 10 cycles with requests pushing, then back-to-back write.
    plan_txn(DMI_OP_READ, 7'h44, 32'h0, 1, 0, 32'h0BADC0DE, 0, 10, 0, 1, 1);
    exec();
    plan_txn(DMI_OP_WRITE, 7'h45, 32'h55AA55AA, 0, 0, 32'h0, 0, 0, 1, 0, 0);
    exec();

    // Completion exactly at the timeout limit, and rvalid one cycle too late.
    plan_txn(DMI_OP_READ, 7'h50, 32'h0, 3, 0, 32'h13572468, 0, 0, 0, 0, 0);
    exec();
    check("lit_edge_done_resp", 64'(first_data), 64'({7'h50, 32'h13572468, 2'b00}));
    plan_txn(DMI_OP_READ, 7'h51, 32'h0, 1, 3, 32'h11111111, 0, 0, 1, 0, 0);
    exec();
    check("lit_edge_late_resp", 64'(first_data), 64'({7'h51, 32'h0, 2'b10}));

    // Reset while waiting for rvalid; the in-flight rvalid lands in IDLE.
    clear_plan();
    s_valid[0] = 1; s_op[0] = DMI_OP_READ; s_addr[0] = 7'h22;
    e_ready[1] = 0; e_dmreq[1] = 1; e_addr[1] = 7'h22; e_we[1] = 0; e_wdata[1] = s_wdata[0];
    s_gnt[1] = 1;
    e_ready[2] = 0; s_rst[2] = 1;
    e_zero[3] = 1; s_rvalid[3] = 1;
    e_zero[4] = 1;
    plan_len = 5;
    exec();
    check("lit_reset_no_resp", 64'(first_rel), 64'hFFFF_FFFF_FFFF_FFFF);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      int sel;
      logic [1:0] op;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) op = DMI_OP_NOP;
      else if (sel == 1) op = 2'b11;
      else op = sel[0] ? DMI_OP_READ : DMI_OP_WRITE;
      plan_txn(op, 7'($urandom), $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
               $urandom, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               1'($urandom), 1'($urandom));
      exec();
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
